// File: rtl/dl_mem_writer.sv
// Download-to-memory writer: toggle-strobe words queued in a small FIFO and written via req/ack.
// Optional checksum output enabled by defining DL_MEM_WRITER_CHECKSUM_EN.
module dl_mem_writer #(
   parameter int FIFO_AW = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dl_strobe,
   input  logic [15:0] dl_data,
   input  logic [22:0] dl_addr,
   input  logic        dl_active,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [22:0] mem_addr,
   output logic [15:0] mem_din,
   output logic        busy,
   output logic        done,
   output logic        overflow,
`ifdef DL_MEM_WRITER_CHECKSUM_EN
   output logic [15:0] checksum,
`endif
   output logic [22:0] word_count
);

   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic {IDLE, REQ} state_e;

   logic [38:0]      fifo_q [DEPTH];
   logic [FIFO_AW:0] wr_q, rd_q, cnt, rd_nxt;
   logic             strobe_q, init_q, active_q, end_q, ovf_q, ovf_d, end_d;
   state_e           state_q, state_d;
   logic [22:0]      addr_q, addr_d, wc_q, wc_d, wc_base;
   logic [15:0]      din_q, din_d;
   logic [38:0]      new_w;
   logic             empty, full, detect, push, pop, push_ok, drop, rise;

   assign cnt    = wr_q - rd_q;
   assign rd_nxt = rd_q + 1'b1;
   assign empty  = (wr_q == rd_q);
   assign full   = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                   (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
   assign new_w  = {dl_addr, dl_data};

   // init_q blocks detection while strobe_q still holds its reset value
   assign detect  = init_q & (dl_strobe ^ strobe_q);
   assign push    = detect & dl_active;
   assign pop     = (state_q == REQ) & mem_ack;
   assign push_ok = push & (~full | pop);
   assign drop    = push & full & ~pop;
   assign rise    = dl_active & ~active_q;

   assign mem_req    = (state_q == REQ);
   assign mem_addr   = addr_q;
   assign mem_din    = din_q;
   assign busy       = ~empty | mem_req;
   assign overflow   = ovf_q;
   assign word_count = wc_q;
   assign done       = end_q & ~dl_active & empty & (state_q == IDLE);

   // Output registers load the word that will be at the head next cycle
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      din_d   = din_q;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d         = REQ;
               {addr_d, din_d} = fifo_q[rd_q[FIFO_AW-1:0]];
            end else if (push_ok) begin
               state_d         = REQ;
               {addr_d, din_d} = new_w;
            end
         end
         REQ: begin
            if (pop) begin
               if (cnt > (FIFO_AW+1)'(1))
                  {addr_d, din_d} = fifo_q[rd_nxt[FIFO_AW-1:0]];
               else if (push_ok)
                  {addr_d, din_d} = new_w;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wc_base = rise ? '0 : wc_q;
      wc_d    = wc_base;
      if (pop && !(&wc_base))
         wc_d = wc_base + 1'b1;
      ovf_d = (rise ? 1'b0 : ovf_q) | drop;
      end_d = rise ? 1'b1 : (done ? 1'b0 : end_q);
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_q[wr_q[FIFO_AW-1:0]] <= new_w;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q     <= '0;
         rd_q     <= '0;
         strobe_q <= 1'b0;
         init_q   <= 1'b0;
         active_q <= 1'b0;
         end_q    <= 1'b0;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
         addr_q   <= '0;
         din_q    <= '0;
         wc_q     <= '0;
      end else begin
         strobe_q <= dl_strobe;
         init_q   <= 1'b1;
         active_q <= dl_active;
         end_q    <= end_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         wc_q     <= wc_d;
         if (push_ok)
            wr_q <= wr_q + 1'b1;
         if (pop)
            rd_q <= rd_nxt;
      end
   end

`ifdef DL_MEM_WRITER_CHECKSUM_EN
   logic [15:0] cs_q, cs_base;

   assign cs_base  = rise ? 16'h0 : cs_q;
   assign checksum = cs_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cs_q <= '0;
      else
         cs_q <= pop ? cs_base + din_q : cs_base;
   end
`endif

endmodule

// File: doc/dl_mem_writer.md
DL_MEM_WRITER -- requirements
Module: dl_mem_writer

Interface
REQ-001 SHALL have parameter FIFO_AW, default 2, meaning log2 of write-FIFO depth (4 entries).
REQ-002 SHALL have port clk, input, 1, system clock; all logic in this domain.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port dl_strobe, input, 1, toggle strobe; every change of level marks one new word.
REQ-005 SHALL have port dl_data, input, 16, download word, valid when dl_strobe toggles.
REQ-006 SHALL have port dl_addr, input, 23, word address [23:1], valid with dl_data.
REQ-007 SHALL have port dl_active, input, 1, download in progress (level).
REQ-008 SHALL have port mem_req, output, 1, write request level to memory arbiter.
REQ-009 SHALL have port mem_ack, input, 1, one-cycle write-accepted pulse.
REQ-010 SHALL have port mem_addr, output, 23, write word address.
REQ-011 SHALL have port mem_din, output, 16, write data.
REQ-012 SHALL have port busy, output, 1, FIFO non-empty or request outstanding.
REQ-013 SHALL have port done, output, 1, one-cycle pulse: download finished and all words written.
REQ-014 SHALL have port overflow, output, 1, sticky: at least one word dropped.
REQ-015 SHALL have port word_count, output, 23, words acknowledged this download, saturating at all-ones.

Function
REQ-016 SHALL detect a word when dl_strobe differs from its one-cycle-delayed copy; the first cycle after reset release loads the copy only, without detecting a word.
REQ-017 SHALL push {dl_addr, dl_data} into the FIFO in the detect cycle if dl_active=1; a word detected while dl_active=0 is ignored.
REQ-018 SHALL, when the FIFO is full and no pop occurs in the same cycle, drop the word and set overflow.
REQ-019 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle.
REQ-020 SHALL implement FSM IDLE/REQ: IDLE->REQ when the FIFO is non-empty; REQ->IDLE on mem_ack with FIFO empty after pop; REQ->REQ (next head) on mem_ack with entries left.
REQ-021 SHALL drive mem_req=1 only in REQ and hold mem_addr/mem_din at FIFO head, stable until mem_ack.
REQ-022 SHALL pop the head and increment word_count on the mem_ack cycle while in REQ; mem_ack outside REQ SHALL be ignored.
REQ-023 SHALL give latency: word detected in cycle N with FSM idle and FIFO empty -> mem_req=1 in cycle N+1.
REQ-024 SHALL, on each rising edge of dl_active, clear word_count and overflow and arm an end flag; this does not affect FIFO contents.
REQ-025 SHALL pulse done for one cycle when the end flag is armed, dl_active=0, FIFO empty and FSM idle, then disarm the flag.
REQ-026 SHALL wrap FIFO pointers modulo 2^FIFO_AW and use an extra pointer bit for full/empty.
REQ-027 SHALL keep busy = (FIFO non-empty) | mem_req.

Reset
REQ-028 SHALL, while reset_n=0, hold mem_req=0, mem_addr=0, mem_din=0, busy=0, done=0, overflow=0, word_count=0, FIFO empty, FSM IDLE, end flag disarmed.
REQ-029 SHALL drop mem_req immediately on reset assertion mid-request, discard queued words, and not emit done.

Configuration
REQ-030 SHALL, with macro DL_MEM_WRITER_CHECKSUM_EN defined, add output checksum (16 bits; reset 0; cleared on rising dl_active) accumulating mem_din modulo 2^16 on every acknowledged write.
REQ-031 SHALL, without DL_MEM_WRITER_CHECKSUM_EN, have no checksum port or logic; all other behaviour is identical.

Verification
REQ-032 SHALL test single word: dl_active=1, toggle with addr 0x700000, data 0xA55A -> mem_req next cycle; 0x700000/0xA55A held; ack -> word_count=1, mem_req=0.
REQ-033 SHALL test back-to-back: 4 toggles on consecutive cycles, ack withheld 10 cycles -> no overflow; 4 writes in order; mem_req stays 1 between acks.
REQ-034 SHALL test overflow: 6 toggles with no ack -> overflow=1; exactly the first 4 words written after acks.
REQ-035 SHALL test end of download: dl_active falls with 2 queued -> done pulses one cycle, one cycle after 2nd ack; busy=0.
REQ-036 SHALL test reset mid-request: reset_n low while mem_req=1 -> all outputs 0 at once; no done after release; first post-reset cycle detects no word.
REQ-037 SHALL test checksum (macro defined): write 0xFFFF, 0x0002 -> checksum=0x0001.
